// File: rtl/mem_read_arbiter_if.sv
// AXI-lite read channel bundle (AR + R) shared by requesters and memory.
// master drives address and rready; slave answers with arready and data.
interface mem_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;
  logic              rresp;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid, rresp
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid, rresp
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-master (IFU/LSU) read arbiter with response watchdog, one txn in flight.
// Define ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module mem_read_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  mem_read_arbiter_if.slave  ifu,
  mem_read_arbiter_if.slave  lsu,
  mem_read_arbiter_if.master m,
  output logic busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       timer;

  logic sel;
  logic idle;
  logic in_data;
  logic in_err;
  logic take;
  logic done;
  logic g_rready;

`ifdef ARB_RR_EN
  logic last_grant;

  always_comb begin
    if (ifu.arvalid && lsu.arvalid) sel = ~last_grant;
    else                            sel = lsu.arvalid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant <= 1'b1;
    else if (take) last_grant <= sel;
  end
`else
  always_comb sel = lsu.arvalid;
`endif

  assign idle     = (state == S_IDLE);
  assign in_data  = (state == S_DATA);
  assign in_err   = (state == S_ERR);
  // Gated by rst so every upstream output reads 0 while reset is held.
  assign take     = idle && !rst && (sel ? lsu.arvalid : ifu.arvalid);
  assign g_rready = grant ? lsu.rready : ifu.rready;
  assign done     = in_data && m.rvalid && g_rready;

  assign ifu.arready = take && !sel;
  assign lsu.arready = take && sel;

  assign m.arvalid = (state == S_ADDR);
  assign m.araddr  = addr_q;
  // Idle keeps rready high to drain late beats from timed-out requests.
  assign m.rready  = idle || (in_data && g_rready);

  assign ifu.rvalid = !grant && ((in_data && m.rvalid) || in_err);
  assign lsu.rvalid =  grant && ((in_data && m.rvalid) || in_err);
  assign ifu.rdata  = (!grant && in_data) ? m.rdata : {DATA_W{1'b0}};
  assign lsu.rdata  = ( grant && in_data) ? m.rdata : {DATA_W{1'b0}};
  assign ifu.rresp  = !grant && ((in_data && m.rresp) || in_err);
  assign lsu.rresp  =  grant && ((in_data && m.rresp) || in_err);

  assign busy = !idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      grant  <= 1'b0;
      addr_q <= '0;
      timer  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            addr_q <= sel ? lsu.araddr : ifu.araddr;
            grant  <= sel;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m.arready) begin
            timer <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          // A completion on the expiry cycle beats the watchdog.
          if (done) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + 16'd1;
            if (timer == T_LAST) state <= S_ERR;
          end
        end
        S_ERR: begin
          if (g_rready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: vector table, corner sequences, random traffic
// against a transaction-level model of masters, slave and arbitration rule.
module tb_mem_read_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(64)) ifu_bus ();
  mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(64)) lsu_bus ();
  mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(64)) m_bus ();

  mem_read_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .ifu  (ifu_bus),
    .lsu  (lsu_bus),
    .m    (m_bus),
    .busy (busy)
  );

  typedef struct {
    int          who;
    logic [31:0] addr;
    int          lat;
    int          rdel;
    bit          sresp;
    bit          exp_resp;
    bit          exp_err;
  } vec_t;

  vec_t tbl[7];

  int n_cmp = 0;
  int n_fail = 0;

  // master model: 0 none, 1 requesting, 2 waiting for data
  int          mst_st[2];
  logic [31:0] mst_addr[2];
  int          mst_rdel[2];
  int          mst_rcnt[2];

  bit inflight, ar_done;
  int g, last;
  int grant_log[$];

  // slave model
  bit          s_pend, s_never, s_inject, s_resp_cfg, s_resp_q;
  logic [31:0] s_addr;
  int          s_cnt, s_lat_fixed, cur_lat, s_ar_mode;

  bit          refill, rnd_req, delivered, d_resp;
  logic [63:0] d_data;
  int          seq_addr;

  function automatic logic [63:0] memval(logic [31:0] a);
    return (a == 32'h8000_0000) ? 64'h0000_0013_0000_0297 : {~a, a};
  endfunction

  function automatic logic rv(int i);
    return (i == 0) ? ifu_bus.rvalid : lsu_bus.rvalid;
  endfunction

  function automatic logic rr(int i);
    return (i == 0) ? ifu_bus.rready : lsu_bus.rready;
  endfunction

  function automatic logic ar(int i);
    return (i == 0) ? ifu_bus.arready : lsu_bus.arready;
  endfunction

  function automatic logic [63:0] rd(int i);
    return (i == 0) ? ifu_bus.rdata : lsu_bus.rdata;
  endfunction

  function automatic logic rs(int i);
    return (i == 0) ? ifu_bus.rresp : lsu_bus.rresp;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue(int i, logic [31:0] a, int rdel);
    mst_st[i]   = 1;
    mst_addr[i] = a;
    mst_rdel[i] = rdel;
    mst_rcnt[i] = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) mst_st[i] = 0;
    inflight = 0;
    ar_done  = 0;
    last     = 1;
    s_pend   = 0;
    s_inject = 0;
    s_never  = 0;
    grant_log.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (refill && mst_st[i] == 0) begin
        issue(i, 32'h8000_2000 + 32'(seq_addr * 8), 0);
        seq_addr++;
      end
      if (rnd_req && mst_st[i] == 0 && $urandom_range(0, 2) == 0)
        issue(i, $urandom, int'($urandom_range(0, 3)));
    end
    ifu_bus.arvalid = (mst_st[0] == 1);
    ifu_bus.araddr  = mst_addr[0];
    ifu_bus.rready  = (mst_st[0] == 2) && (mst_rcnt[0] >= mst_rdel[0]);
    lsu_bus.arvalid = (mst_st[1] == 1);
    lsu_bus.araddr  = mst_addr[1];
    lsu_bus.rready  = (mst_st[1] == 2) && (mst_rcnt[1] >= mst_rdel[1]);
    case (s_ar_mode)
      0:       m_bus.arready = 1'b1;
      1:       m_bus.arready = 1'($urandom_range(0, 1));
      default: m_bus.arready = 1'b0;
    endcase
    m_bus.rvalid = s_inject || (s_pend && !s_never && s_cnt == 0);
    m_bus.rdata  = s_inject ? 64'hBAD0_BAD0_BAD0_BAD0 : memval(s_addr);
    m_bus.rresp  = s_inject ? 1'b0 : s_resp_q;
  endtask

  task automatic sample();
    bit ri, rl, exp_err;
    int exp_sel;
    ri = (mst_st[0] == 1);
    rl = (mst_st[1] == 1);
    if (ri || rl) begin
      if (inflight) begin
        chk("arready_busy", {ifu_bus.arready, lsu_bus.arready}, 0);
      end else begin
`ifdef ARB_RR_EN
        exp_sel = (ri && rl) ? ((last == 0) ? 1 : 0) : (rl ? 1 : 0);
`else
        exp_sel = rl ? 1 : 0;
`endif
        chk("arb_sel", {ifu_bus.arready, lsu_bus.arready},
            (exp_sel == 1) ? 2'b01 : 2'b10);
      end
    end
    chk("busy", busy, inflight);
    chk("m_arvalid", m_bus.arvalid, inflight && !ar_done);
    if (m_bus.arvalid) chk("m_araddr", m_bus.araddr, mst_addr[g]);
    for (int i = 0; i < 2; i++)
      if (!(inflight && g == i)) chk("stray_rvalid", rv(i), 0);
    // slave side
    if (m_bus.rvalid && m_bus.rready) begin
      if (s_inject) s_inject = 0;
      else          s_pend   = 0;
    end else if (s_pend && s_cnt > 0) begin
      s_cnt--;
    end
    if (m_bus.arvalid && m_bus.arready) begin
      s_pend   = 1;
      s_addr   = m_bus.araddr;
      s_cnt    = (s_lat_fixed >= 0) ? s_lat_fixed : int'($urandom_range(0, 6));
      cur_lat  = s_never ? 1000 : s_cnt;
      s_resp_q = (s_lat_fixed >= 0) ? s_resp_cfg : 1'($urandom_range(0, 1));
      ar_done  = 1;
    end
    // upstream responses
    for (int i = 0; i < 2; i++) begin
      if (mst_st[i] == 2 && rv(i)) begin
        if (rr(i)) begin
          exp_err = (cur_lat + mst_rdel[i] >= TO);
          chk("rdata", rd(i), exp_err ? 64'd0 : memval(mst_addr[i]));
          chk("rresp", rs(i), exp_err ? 1'b1 : s_resp_q);
          delivered = 1;
          d_data    = rd(i);
          d_resp    = rs(i);
          mst_st[i] = 0;
          inflight  = 0;
          ar_done   = 0;
        end else begin
          mst_rcnt[i]++;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (mst_st[i] == 1 && ar(i)) begin
        mst_st[i]   = 2;
        mst_rcnt[i] = 0;
        inflight    = 1;
        g           = i;
        last        = i;
        grant_log.push_back(i);
      end
    end
  endtask

  task automatic pre_cyc();
    drive();
    #1;
  endtask

  task automatic post_cyc();
    sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    pre_cyc();
    post_cyc();
  endtask

  task automatic wait_idle(int bound);
    int k;
    k = 0;
    while (!(mst_st[0] == 0 && mst_st[1] == 0 && !inflight) && k < bound) begin
      step();
      k++;
    end
    chk("wait_idle", (mst_st[0] == 0 && mst_st[1] == 0 && !inflight), 1);
  endtask

  task automatic wait_delivered(string nm, int bound);
    int k;
    k = 0;
    delivered = 0;
    while (!delivered && k < bound) begin
      step();
      k++;
    end
    chk(nm, delivered, 1);
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, "_ifu_arready"}, ifu_bus.arready, 0);
    chk({nm, "_lsu_arready"}, lsu_bus.arready, 0);
    chk({nm, "_m_arvalid"},   m_bus.arvalid, 0);
    chk({nm, "_m_araddr"},    m_bus.araddr, 0);
    chk({nm, "_m_rready"},    m_bus.rready, 1);
    chk({nm, "_rvalid"},      {ifu_bus.rvalid, lsu_bus.rvalid}, 0);
    chk({nm, "_rdata"},       ifu_bus.rdata | lsu_bus.rdata, 0);
    chk({nm, "_busy"},        busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit seen;
    tbl[0] = '{0, 32'h8000_0100, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1, 32'h8000_1000, 3, 0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{0, 32'h8000_0200, 7, 0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1, 32'h8000_1100, 5, 2, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{0, 32'h8000_0300, 5, 3, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1, 32'h8000_1200, 0, 3, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{0, 32'h8000_0400, 2, 6, 1'b0, 1'b1, 1'b1};

    refill      = 0;
    rnd_req     = 0;
    seq_addr    = 0;
    s_ar_mode   = 0;
    s_lat_fixed = 0;
    s_resp_cfg  = 0;
    s_resp_q    = 0;
    s_addr      = '0;
    s_cnt       = 0;
    cur_lat     = 0;
    g           = 0;
    for (int i = 0; i < 2; i++) begin
      mst_addr[i] = '0;
      mst_rdel[i] = 0;
      mst_rcnt[i] = 0;
    end
    model_clear();

    rst = 1'b1;
    drive();
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    // single IFU read, zero-wait slave
    issue(0, 32'h8000_0000, 0);
    pre_cyc();
    chk("c0_ifu_arready", ifu_bus.arready, 1);
    chk("c0_lsu_rvalid", lsu_bus.rvalid, 0);
    post_cyc();
    pre_cyc();
    chk("c1_m_arvalid", m_bus.arvalid, 1);
    chk("c1_m_araddr", m_bus.araddr, 32'h8000_0000);
    post_cyc();
    pre_cyc();
    chk("c2_ifu_rvalid", ifu_bus.rvalid, 1);
    chk("c2_ifu_rdata", ifu_bus.rdata, 64'h0000_0013_0000_0297);
    chk("c2_ifu_rresp", ifu_bus.rresp, 0);
    chk("c2_lsu_rvalid", lsu_bus.rvalid, 0);
    post_cyc();
    step();

    // vector table: latency / rready hold / slave error / watchdog
    for (int v = 0; v < 7; v++) begin
      s_lat_fixed = tbl[v].lat;
      s_resp_cfg  = tbl[v].sresp;
      issue(tbl[v].who, tbl[v].addr, tbl[v].rdel);
      wait_delivered("tbl_done", 40);
      chk("tbl_resp", d_resp, tbl[v].exp_resp);
      chk("tbl_data", d_data, tbl[v].exp_err ? 64'd0 : memval(tbl[v].addr));
    end
    step();
    step();

    // simultaneous requests from reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_clear();
    s_lat_fixed = 1;
    s_resp_cfg  = 0;
    issue(0, 32'h8000_0004, 0);
    issue(1, 32'h8000_1000, 0);
    pre_cyc();
`ifdef ARB_RR_EN
    chk("both_first", {ifu_bus.arready, lsu_bus.arready}, 2'b10);
`else
    chk("both_first", {ifu_bus.arready, lsu_bus.arready}, 2'b01);
`endif
    post_cyc();
    wait_idle(40);
    chk("both_n", grant_log.size(), 2);
`ifdef ARB_RR_EN
    chk("both_order0", grant_log[0], 0);
    chk("both_order1", grant_log[1], 1);
`else
    chk("both_order0", grant_log[0], 1);
    chk("both_order1", grant_log[1], 0);
`endif

    // continuous requests from both
    grant_log.delete();
    refill = 1;
    for (int k = 0; k < 100 && grant_log.size() < 6; k++) step();
    refill = 0;
    wait_idle(40);
    chk("cont_n", grant_log.size() >= 6, 1);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
`ifdef ARB_RR_EN
      chk("cont_order", grant_log[k], (k % 2 == 0) ? 0 : 1);
`else
      chk("cont_order", grant_log[k], 1);
`endif

    // watchdog: slave never answers
    s_never = 1;
    issue(0, 32'h8000_3000, 0);
    step();
    step();
    cnt  = 0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      pre_cyc();
      if (ifu_bus.rvalid) begin
        seen = 1;
        chk("to_rdata", ifu_bus.rdata, 0);
        chk("to_rresp", ifu_bus.rresp, 1);
        post_cyc();
        break;
      end
      post_cyc();
      cnt++;
    end
    chk("to_seen", seen, 1);
    chk("to_cycles", cnt, TO);
    s_never = 0;
    s_pend  = 0;
    step();
    s_inject = 1;
    pre_cyc();
    chk("stale_m_rready", m_bus.rready, 1);
    chk("stale_ifu_rvalid", ifu_bus.rvalid, 0);
    chk("stale_lsu_rvalid", lsu_bus.rvalid, 0);
    post_cyc();
    step();

    // master holds rready low for 3 cycles
    s_lat_fixed = 0;
    s_resp_cfg  = 0;
    issue(1, 32'h8000_4000, 3);
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      pre_cyc();
      chk("hold_m_rready", m_bus.rready, 0);
      chk("hold_rvalid", lsu_bus.rvalid, 1);
      chk("hold_rdata", lsu_bus.rdata, memval(32'h8000_4000));
      post_cyc();
    end
    pre_cyc();
    chk("hold_done_m_rready", m_bus.rready, 1);
    chk("hold_done_rvalid", lsu_bus.rvalid, 1);
    post_cyc();
    pre_cyc();
    chk("hold_busy_fall", busy, 0);
    post_cyc();

    // asynchronous reset while in S_ADDR
    s_ar_mode = 2;
    issue(0, 32'h8000_5000, 0);
    step();
    pre_cyc();
    chk("rst_pre_arvalid", m_bus.arvalid, 1);
    rst = 1'b1;
    #1;
    chk_reset_outs("rst_addr");
    #1;
    rst = 1'b0;
    model_clear();
    s_ar_mode = 0;
    @(posedge clk);
    @(negedge clk);
    issue(0, 32'h8000_6000, 0);
    wait_delivered("rst_after_done", 20);
    chk("rst_after_data", d_data, memval(32'h8000_6000));
    chk("rst_after_resp", d_resp, 0);
    step();

    // randomized traffic against the model
    s_lat_fixed = -1;
    s_ar_mode   = 1;
    rnd_req     = 1;
    for (int k = 0; k < 400; k++) step();
    rnd_req = 0;
    wait_idle(200);
    s_ar_mode = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
